// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and constants for the ALU operand sequencer
//
// Purpose : sequencer state encoding, pushbutton index map, ALU opcode type
//           and the switch-to-operand conversion helper.
// Contents: seq_state_t, KEY_ENTER/KEY_CANCEL/KEY_CHAIN, aluop_t, ALUOP_*,
//           operand_value().
package cpu_types_pkg;

   // Encodings are shown directly on the stage LEDs, so they are fixed.
   typedef enum logic [2:0] {
      ST_ENTER_A  = 3'd0,
      ST_ENTER_B  = 3'd1,
      ST_ENTER_OP = 3'd2,
      ST_EXEC     = 3'd3,
      ST_SHOW     = 3'd4
   } seq_state_t;

   localparam int KEY_ENTER  = 0;
   localparam int KEY_CANCEL = 1;
   localparam int KEY_CHAIN  = 2;

   typedef logic [3:0] aluop_t;

   localparam aluop_t ALUOP_AND = 4'h0;
   localparam aluop_t ALUOP_OR  = 4'h1;
   localparam aluop_t ALUOP_ADD = 4'h2;
   localparam aluop_t ALUOP_SUB = 4'h6;

   // sw[16] fills the upper half with ones so negative operands can be keyed in.
   function automatic logic [31:0] operand_value(input logic [16:0] sw_val);
      return {sw_val[16] ? 16'hFFFF : 16'h0000, sw_val[15:0]};
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer plus counting debouncer for one active-low key
//
// Purpose : bring a raw pushbutton into the clock domain, accept a level change
//           only after DEBOUNCE_CYCLES consecutive disagreeing samples, and
//           emit a one-cycle pulse on each released-to-pressed transition.
// Ports   : CLK   - clock
//           RST   - synchronous active-high reset
//           key_n - raw key, active-low
//           level - debounced key level (1 = released)
//           press - one-cycle pulse when the debounced level becomes pressed
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic RST,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else begin
         // Saturating count of consecutive disagreeing samples.
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
         end
         if (cnt_d == CNT_MAX) begin
            level_d = sync2_q;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= level_q & ~level_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/alu_operand_seq.sv
// rtl/alu_operand_seq.sv - pushbutton-driven operand/opcode sequencer in front of the ALU
//
// Purpose : debounce ENTER/CANCEL/CHAIN, step ENTER_A -> ENTER_B -> ENTER_OP ->
//           EXEC -> SHOW, drive porta/portb/aluop and latch the ALU result.
// Ports   : CLK, RST (sync, active-high); key_n[3:0] raw keys (active-low);
//           sw[16:0] switches; porto/negative/overflow/zero from the ALU;
//           porta/portb/aluop to the ALU; result/flags/result_valid latched
//           output; stage = current state for LEDs.
// Config  : OPERAND_SEQ_CHAIN_EN enables the CHAIN key (SHOW -> ENTER_B with
//           porta <= result). Undefined: CHAIN is ignored entirely.
module alu_operand_seq
   import cpu_types_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  key_n,
   input  logic [16:0] sw,
   input  logic [31:0] porto,
   input  logic        negative,
   input  logic        overflow,
   input  logic        zero,
   output logic [31:0] porta,
   output logic [31:0] portb,
   output aluop_t      aluop,
   output logic [31:0] result,
   output logic [2:0]  flags,
   output logic [2:0]  stage,
   output logic        result_valid
);

   logic enter_p, cancel_p, chain_p;
   logic enter_level, cancel_level, chain_level;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
      .CLK   (CLK),
      .RST   (RST),
      .key_n (key_n[KEY_ENTER]),
      .level (enter_level),
      .press (enter_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
      .CLK   (CLK),
      .RST   (RST),
      .key_n (key_n[KEY_CANCEL]),
      .level (cancel_level),
      .press (cancel_p)
   );

`ifdef OPERAND_SEQ_CHAIN_EN
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_chain (
      .CLK   (CLK),
      .RST   (RST),
      .key_n (key_n[KEY_CHAIN]),
      .level (chain_level),
      .press (chain_p)
   );
`else
   assign chain_p     = 1'b0;
   assign chain_level = 1'b1;
`endif

   // Debounced levels and the spare key have no consumer here.
   logic unused_ok;
   assign unused_ok = &{1'b0, enter_level, cancel_level, chain_level, key_n[3], key_n[2]};

   seq_state_t  state_q;
   logic [31:0] porta_q, portb_q, result_q;
   aluop_t      aluop_q;
   logic [2:0]  flags_q;
   logic        valid_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_ENTER_A;
         porta_q  <= '0;
         portb_q  <= '0;
         aluop_q  <= '0;
         result_q <= '0;
         flags_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_ENTER_A: begin
               if (cancel_p) begin
                  state_q <= ST_ENTER_A;
               end else if (enter_p) begin
                  porta_q <= operand_value(sw);
                  state_q <= ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               if (cancel_p) begin
                  state_q <= ST_ENTER_A;
               end else if (enter_p) begin
                  portb_q <= operand_value(sw);
                  state_q <= ST_ENTER_OP;
               end
            end
            ST_ENTER_OP: begin
               if (cancel_p) begin
                  state_q <= ST_ENTER_A;
               end else if (enter_p) begin
                  aluop_q <= sw[3:0];
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // The ALU is combinational off the registered operands, so
               // porto is already valid in this single cycle.
               result_q <= porto;
               flags_q  <= {negative, overflow, zero};
               valid_q  <= 1'b1;
               state_q  <= ST_SHOW;
            end
            ST_SHOW: begin
               if (chain_p) begin
                  porta_q <= result_q;
                  valid_q <= 1'b0;
                  state_q <= ST_ENTER_B;
               end else if (enter_p) begin
                  valid_q <= 1'b0;
                  state_q <= ST_ENTER_A;
               end
            end
            default: state_q <= ST_ENTER_A;
         endcase
      end
   end

   assign porta        = porta_q;
   assign portb        = portb_q;
   assign aluop        = aluop_q;
   assign result       = result_q;
   assign flags        = flags_q;
   assign stage        = state_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// tb/tb_alu_operand_seq.sv - directed self-checking bench for alu_operand_seq
module tb_alu_operand_seq;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  key_n;
   logic [16:0] sw;
   logic [31:0] porto;
   logic        negative, overflow, zero;
   logic [31:0] porta, portb, result;
   aluop_t      aluop;
   logic [2:0]  flags, stage;
   logic        result_valid;

   int tests  = 0;
   int failed = 0;
   logic [34:0] exp_q[$];

   always #5 CLK = ~CLK;

   alu_operand_seq #(.DEBOUNCE_CYCLES(4)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .key_n        (key_n),
      .sw           (sw),
      .porto        (porto),
      .negative     (negative),
      .overflow     (overflow),
      .zero         (zero),
      .porta        (porta),
      .portb        (portb),
      .aluop        (aluop),
      .result       (result),
      .flags        (flags),
      .stage        (stage),
      .result_valid (result_valid)
   );

   // Returns {negative, overflow, zero, result}.
   function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
      logic [31:0] r;
      logic        ov;
      ov = 1'b0;
      case (op)
         ALUOP_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         ALUOP_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         ALUOP_AND: r = a & b;
         ALUOP_OR:  r = a | b;
         default:   r = 32'h0;
      endcase
      return {r[31], ov, (r == 32'h0), r};
   endfunction

   assign {negative, overflow, zero, porto} = alu_model(porta, portb, aluop);

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press_keys(input logic [3:0] mask);
      key_n = ~mask;
      tick(8);
      key_n = 4'hF;
      tick(8);
   endtask

   // Waits a bounded number of cycles for result_valid, then pops and compares.
   task automatic wait_result(output int n);
      logic [34:0] e;
      n = 0;
      while (!result_valid && n < 50) begin
         tick(1);
         n++;
      end
      check("result_valid_seen", {31'h0, result_valid}, 32'h1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("result", result, e[31:0]);
         check("flags", {29'h0, flags}, {29'h0, e[34:32]});
      end else begin
         check("scoreboard_nonempty", 32'h0, 32'h1);
      end
   endtask

   // ENTER on ENTER_OP with exact latency checks: EXEC after 7 edges, valid one later.
   task automatic exec_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      int n;
      sw = {13'h0, op};
      exp_q.push_back(alu_model(a, b, op));
      key_n[KEY_ENTER] = 1'b0;
      tick(7);
      check("stage_exec", {29'h0, stage}, 32'd3);
      check("valid_low_in_exec", {31'h0, result_valid}, 32'h0);
      wait_result(n);
      check("exec_to_valid_latency", n, 32'd1);
      check("stage_show", {29'h0, stage}, 32'd4);
      check("aluop", {28'h0, aluop}, {28'h0, op});
      key_n = 4'hF;
      tick(8);
   endtask

   initial begin
      RST   = 1'b1;
      key_n = 4'hF;
      sw    = '0;
      tick(3);
      RST = 1'b0;
      tick(20);
      check("reset_stage", {29'h0, stage}, 32'd0);
      check("reset_porta", porta, 32'h0);
      check("reset_portb", portb, 32'h0);
      check("reset_result", result, 32'h0);
      check("reset_valid", {31'h0, result_valid}, 32'h0);
      check("reset_aluop", {28'h0, aluop}, 32'h0);
      check("reset_flags", {29'h0, flags}, 32'h0);

      // Bouncy press never stable for 4 samples.
      sw = 17'h00009;
      key_n[0] = 1'b0; tick(1);
      key_n[0] = 1'b1; tick(1);
      key_n[0] = 1'b0; tick(3);
      key_n[0] = 1'b1; tick(10);
      check("bounce_stage", {29'h0, stage}, 32'd0);
      check("bounce_porta", porta, 32'h0);

      // 5 + 3 = 8
      sw = 17'h00005;
      press_keys(4'b0001);
      check("a_stage", {29'h0, stage}, 32'd1);
      check("a_porta", porta, 32'h5);
      sw = 17'h00003;
      press_keys(4'b0001);
      check("b_stage", {29'h0, stage}, 32'd2);
      check("b_portb", portb, 32'h3);
      exec_op(32'h5, 32'h3, ALUOP_ADD);
      check("add_result_8", result, 32'h8);

      // CANCEL is ignored in SHOW.
      press_keys(4'b0010);
      check("show_cancel_stage", {29'h0, stage}, 32'd4);
      check("show_cancel_valid", {31'h0, result_valid}, 32'h1);

      press_keys(4'b0100);
`ifdef OPERAND_SEQ_CHAIN_EN
      check("chain_stage", {29'h0, stage}, 32'd1);
      check("chain_porta", porta, 32'h8);
      check("chain_valid", {31'h0, result_valid}, 32'h0);
      check("chain_result_held", result, 32'h8);
      press_keys(4'b0010);
      check("cancel_b_stage", {29'h0, stage}, 32'd0);
      check("cancel_b_portb", portb, 32'h3);
`else
      check("nochain_stage", {29'h0, stage}, 32'd4);
      check("nochain_porta", porta, 32'h5);
      check("nochain_valid", {31'h0, result_valid}, 32'h1);
      press_keys(4'b0001);
      check("show_enter_stage", {29'h0, stage}, 32'd0);
      check("show_enter_valid", {31'h0, result_valid}, 32'h0);
      check("show_enter_result_held", result, 32'h8);
`endif

      // Upper-fill operand.
      sw = 17'h1FFFF;
      press_keys(4'b0001);
      check("fill_stage", {29'h0, stage}, 32'd1);
      check("fill_porta", porta, 32'hFFFFFFFF);

      // CANCEL and ENTER together in ENTER_B: CANCEL wins.
      sw = 17'h00077;
      press_keys(4'b0011);
      check("prio_stage", {29'h0, stage}, 32'd0);
      check("prio_portb", portb, 32'h3);
      check("prio_porta", porta, 32'hFFFFFFFF);

      // 2 - 7 -> negative result
      sw = 17'h00002;
      press_keys(4'b0001);
      sw = 17'h00007;
      press_keys(4'b0001);
      exec_op(32'h2, 32'h7, ALUOP_SUB);
      press_keys(4'b0001);
      check("after_sub_stage", {29'h0, stage}, 32'd0);

      // Reset while in EXEC.
      sw = 17'h00011;
      press_keys(4'b0001);
      sw = 17'h00022;
      press_keys(4'b0001);
      sw = {13'h0, ALUOP_ADD};
      key_n[KEY_ENTER] = 1'b0;
      tick(7);
      check("rst_pre_exec", {29'h0, stage}, 32'd3);
      RST   = 1'b1;
      key_n = 4'hF;
      tick(1);
      check("rst_exec_stage", {29'h0, stage}, 32'd0);
      check("rst_exec_porta", porta, 32'h0);
      check("rst_exec_portb", portb, 32'h0);
      check("rst_exec_result", result, 32'h0);
      check("rst_exec_valid", {31'h0, result_valid}, 32'h0);
      check("rst_exec_flags", {29'h0, flags}, 32'h0);
      check("rst_exec_aluop", {28'h0, aluop}, 32'h0);
      tick(1);
      RST = 1'b0;
      tick(12);
      check("post_rst_idle_stage", {29'h0, stage}, 32'd0);
      check("post_rst_idle_valid", {31'h0, result_valid}, 32'h0);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
